// File: rtl/dma_copy_pkg.sv
// Shared constants for the dma_copy engine: register map, CTRL/STATUS bit
// positions, FSM encoding and the command/event structs between regs and FSM.
package dma_copy_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_FILL     = 1;
    localparam int CTRL_ABORT    = 2;
    localparam int CTRL_CLR_DONE = 3;
    localparam int CTRL_IRQ_EN   = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_FILL    = 3;
    localparam int STAT_IRQ_EN  = 4;
    localparam int STAT_REM_LSB = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_WR_REQ = 3'd3;
    localparam logic [2:0] S_WR_GAP = 3'd4;

    typedef struct packed {
        logic start;   // accepted start (only ever raised while idle)
        logic abort;   // accepted abort (only ever raised while busy)
    } dma_cmd_t;

    typedef struct packed {
        logic set_done;
        logic set_aborted;
    } dma_evt_t;

endpackage

// File: rtl/dma_copy_if.sv
// Register window and bus-master signals of dma_copy.
// master = DMA side, slave = SoC side (CPU decode, arbiter, responders).
interface dma_copy_if;
    logic        regChipSelect;
    logic        regWrite;
    logic [1:0]  regAddr;
    logic [31:0] regDataIn;
    logic [31:0] regDataOut;
    logic        busRequest;
    logic        busGrant;
    logic [31:0] busAddress;
    logic        busWriteEnable;
    logic        busInstr;
    logic        busValid;
    logic [31:0] busDataOut;
    logic [31:0] busDataIn;
    logic        busReady;
    logic        irq;

    modport master (
        input  regChipSelect, regWrite, regAddr, regDataIn, busGrant, busDataIn, busReady,
        output regDataOut, busRequest, busAddress, busWriteEnable, busInstr, busValid,
               busDataOut, irq
    );

    modport slave (
        output regChipSelect, regWrite, regAddr, regDataIn, busGrant, busDataIn, busReady,
        input  regDataOut, busRequest, busAddress, busWriteEnable, busInstr, busValid,
               busDataOut, irq
    );
endinterface

// File: rtl/dma_copy_regs.sv
// dma_copy register file: SRC/DST/LEN, CTRL decode, STATUS mux, done/abort flags, irq.
// DMA_FILL_EN keeps the low SRC bits as part of the fill pattern and exports fill mode.
module dma_copy_regs
    import dma_copy_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_i,
    input  logic                 we_i,
    input  logic [1:0]           addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    input  logic                 busy_i,
    input  logic                 fill_i,
    input  dma_evt_t             evt_i,
    input  logic [LEN_WIDTH-1:0] rem_i,
    output dma_cmd_t             cmd_o,
    output logic [31:2]          src_o,
    output logic [31:2]          dst_o,
    output logic [LEN_WIDTH-1:0] len_o,
`ifdef DMA_FILL_EN
    output logic                 fill_o,
    output logic [31:0]          pat_o,
`endif
    output logic                 irq_o
);

    logic [31:2]          src_q, dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 done_q, done_d, aborted_q, aborted_d;
    logic                 irq_en_q, irq_en_d, irq_q;
    logic                 wr_any, wr_cfg, wr_ctrl, start;
    logic [31:0]          status;

    assign wr_any  = cs_i & we_i;
    assign wr_cfg  = wr_any & ~busy_i;
    assign wr_ctrl = wr_any & (addr_i == REG_CTRL);
    assign start   = wr_ctrl & wdata_i[CTRL_START] & ~busy_i;

    assign cmd_o.start = start;
    assign cmd_o.abort = wr_ctrl & wdata_i[CTRL_ABORT] & busy_i;

`ifdef DMA_FILL_EN
    logic [1:0] src_lo_q;
    assign fill_o = wdata_i[CTRL_FILL];
    assign pat_o  = {src_q, src_lo_q};
`endif

    // Start outranks clear-done; a zero-length start completes on the next cycle.
    always_comb begin
        done_d    = done_q;
        aborted_d = aborted_q;
        irq_en_d  = irq_en_q;
        if (wr_ctrl) irq_en_d = wdata_i[CTRL_IRQ_EN];
        if (start) begin
            done_d    = (len_q == '0);
            aborted_d = 1'b0;
        end else begin
            if (wr_ctrl & wdata_i[CTRL_CLR_DONE]) done_d = 1'b0;
            if (evt_i.set_done)                   done_d = 1'b1;
            if (evt_i.set_aborted)                aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`ifdef DMA_FILL_EN
            src_lo_q  <= '0;
`endif
        end else begin
            if (wr_cfg && addr_i == REG_SRC) begin
                src_q <= wdata_i[31:2];
`ifdef DMA_FILL_EN
                src_lo_q <= wdata_i[1:0];
`endif
            end
            if (wr_cfg && addr_i == REG_DST) dst_q <= wdata_i[31:2];
            if (wr_cfg && addr_i == REG_LEN) len_q <= wdata_i[LEN_WIDTH-1:0];
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= (done_d | aborted_d) & irq_en_d;
        end
    end

    always_comb begin
        status                               = '0;
        status[STAT_BUSY]                    = busy_i;
        status[STAT_DONE]                    = done_q;
        status[STAT_ABORTED]                 = aborted_q;
        status[STAT_FILL]                    = fill_i;
        status[STAT_IRQ_EN]                  = irq_en_q;
        status[STAT_REM_LSB +: LEN_WIDTH]    = rem_i;
    end

    always_comb begin
        case (addr_i)
            REG_SRC: rdata_o = {src_q, 2'b00};
            REG_DST: rdata_o = {dst_q, 2'b00};
            REG_LEN: rdata_o = 32'(len_q);
            default: rdata_o = status;
        endcase
    end

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign len_o = len_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/dma_copy.sv
// Word-granular memory-to-memory DMA: FSM and valid/ready bus master.
// Optional fill mode (constant SRC pattern to DST) is compiled in with DMA_FILL_EN.
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    dma_copy_if.master bus
);

    logic [2:0]           state_q, state_d;
    logic [31:2]          src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]          data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pend_q, pend_d;
    logic                 busy, fill_mode;

    dma_cmd_t             cmd;
    dma_evt_t             evt;
    logic [31:2]          cfg_src, cfg_dst;
    logic [LEN_WIDTH-1:0] cfg_len;

`ifdef DMA_FILL_EN
    logic                 fill_q, fill_d, cfg_fill;
    logic [31:0]          cfg_pat;
    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    assign busy = (state_q != S_IDLE);

    dma_copy_regs #(.LEN_WIDTH(LEN_WIDTH)) u_regs (
        .clk     (clk),
        .rst     (rst),
        .cs_i    (bus.regChipSelect),
        .we_i    (bus.regWrite),
        .addr_i  (bus.regAddr),
        .wdata_i (bus.regDataIn),
        .rdata_o (bus.regDataOut),
        .busy_i  (busy),
        .fill_i  (fill_mode),
        .evt_i   (evt),
        .rem_i   (rem_q),
        .cmd_o   (cmd),
        .src_o   (cfg_src),
        .dst_o   (cfg_dst),
        .len_o   (cfg_len),
`ifdef DMA_FILL_EN
        .fill_o  (cfg_fill),
        .pat_o   (cfg_pat),
`endif
        .irq_o   (bus.irq)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        pend_d  = pend_q | cmd.abort;
        evt     = '0;
`ifdef DMA_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            S_IDLE: if (cmd.start) begin
                src_d  = cfg_src;
                dst_d  = cfg_dst;
                rem_d  = cfg_len;
                pend_d = 1'b0;
`ifdef DMA_FILL_EN
                fill_d = cfg_fill;
                data_d = cfg_pat;
                if (cfg_len != '0) state_d = cfg_fill ? S_WR_REQ : S_RD_REQ;
`else
                if (cfg_len != '0) state_d = S_RD_REQ;
`endif
            end
            // valid rises only under grant and then holds until the acknowledge
            S_RD_REQ: begin
                if (!valid_q) valid_d = bus.busGrant;
                else if (bus.busReady) begin
                    valid_d = 1'b0;
                    data_d  = bus.busDataIn;
                    src_d   = src_q + 30'd1;
                    state_d = S_RD_GAP;
                end
            end
            S_RD_GAP: state_d = S_WR_REQ;
            S_WR_REQ: begin
                if (!valid_q) valid_d = bus.busGrant;
                else if (bus.busReady) begin
                    valid_d = 1'b0;
                    dst_d   = dst_q + 30'd1;
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = S_WR_GAP;
                end
            end
            // Abort is only honoured here, so a started read always gets its write.
            S_WR_GAP: begin
                if (rem_q == '0) begin
                    state_d      = S_IDLE;
                    evt.set_done = 1'b1;
                end else if (pend_q | cmd.abort) begin
                    state_d         = S_IDLE;
                    evt.set_aborted = 1'b1;
                end else begin
                    state_d = fill_mode ? S_WR_REQ : S_RD_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
`ifdef DMA_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    assign bus.busRequest     = busy;
    assign bus.busValid       = valid_q;
    assign bus.busWriteEnable = (state_q == S_WR_REQ);
    assign bus.busInstr       = 1'b0;
    assign bus.busDataOut     = data_q;
    assign bus.busAddress     = (state_q == S_RD_REQ) ? {src_q, 2'b00} :
                                (state_q == S_WR_REQ) ? {dst_q, 2'b00} : 32'h0;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: table of copy vectors against a ROM/RAM
// responder model, plus hand sequences for abort, reset, priority and fill.
module tb_dma_copy;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dma_copy_if ifc ();
    dma_copy #(.LEN_WIDTH(16)) dut (.clk(clk), .rst(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rdy_dly = 0;

    int rd_beats = 0, wr_beats = 0, gap_viol = 0, stab_viol = 0, gnt_viol = 0, req_cycles = 0;
    int rcnt = 0;
    logic [31:0] wmem [0:255];
    bit          wvld [0:255];
    logic        prev_ack = 1'b0, prev_pend = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_dout = '0;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_96F0;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'({a[19:16], a[5:2]});
    endfunction

    assign ifc.busDataIn = ifc.busReady ? rom_fn(ifc.busAddress) : 32'h0;

    // responder: ready rdy_dly+1 cycles after valid is first seen, held while valid
    always @(posedge clk) begin
        if (!ifc.busValid) begin
            rcnt         <= 0;
            ifc.busReady <= 1'b0;
        end else if (rcnt >= rdy_dly) begin
            ifc.busReady <= 1'b1;
        end else begin
            rcnt <= rcnt + 1;
        end
        if (ifc.busValid && ifc.busReady) begin
            if (ifc.busWriteEnable) begin
                wmem[idx(ifc.busAddress)] <= ifc.busDataOut;
                wvld[idx(ifc.busAddress)] <= 1'b1;
                wr_beats <= wr_beats + 1;
            end else begin
                rd_beats <= rd_beats + 1;
            end
        end
    end

    // protocol monitor
    always @(posedge clk) begin
        if (ifc.busValid && !ifc.busGrant) gnt_viol <= gnt_viol + 1;
        if (ifc.busRequest) req_cycles <= req_cycles + 1;
        if (prev_ack && ifc.busValid) gap_viol <= gap_viol + 1;
        if (prev_pend && (!ifc.busValid || ifc.busAddress !== prev_addr ||
            ifc.busWriteEnable !== prev_we || ifc.busDataOut !== prev_dout))
            stab_viol <= stab_viol + 1;
        prev_ack  <= ifc.busValid & ifc.busReady;
        prev_pend <= ifc.busValid & ~ifc.busReady;
        prev_addr <= ifc.busAddress;
        prev_we   <= ifc.busWriteEnable;
        prev_dout <= ifc.busDataOut;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ifc.regChipSelect = 1'b1;
        ifc.regWrite      = 1'b1;
        ifc.regAddr       = a;
        ifc.regDataIn     = d;
        @(negedge clk);
        ifc.regChipSelect = 1'b0;
        ifc.regWrite      = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        ifc.regAddr = a;
        #1;
        d = ifc.regDataOut;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n = 0;
        rd(2'd3, s);
        while (s[0] && n < 3000) begin
            @(negedge clk);
            rd(2'd3, s);
            n++;
        end
        chk("busy_timeout", {31'b0, s[0]}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          gnt_hold;
        int          dly;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] s;
        int r0, w0, g0, st0, gv0, q0, n;

        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int r0, w0, g0, st0, gv0, q0, n;

        vecs[0] = '{32'h0000_0000, 32'h0001_0000, 16'd4, 0,  0, 4, 4, 32'h0000_0002};
        vecs[1] = '{32'h0000_0040, 32'h0002_0000, 16'd0, 0,  0, 0, 0, 32'h0000_0002};
        vecs[2] = '{32'h0000_0080, 32'h0003_0000, 16'd2, 10, 0, 2, 2, 32'h0000_0002};
        vecs[3] = '{32'h0000_00C0, 32'h0004_0000, 16'd1, 0,  3, 1, 1, 32'h0000_0002};
        vecs[4] = '{32'hFFFF_FFF8, 32'h0005_0000, 16'd3, 0,  1, 3, 3, 32'h0000_0002};

        ifc.regChipSelect = 1'b0;
        ifc.regWrite      = 1'b0;
        ifc.regAddr       = 2'd3;
        ifc.regDataIn     = '0;
        ifc.busGrant      = 1'b1;

        // reset state
        #2;
        chk("rst_valid", {31'b0, ifc.busValid}, 32'h0);
        chk("rst_req",   {31'b0, ifc.busRequest}, 32'h0);
        chk("rst_we",    {31'b0, ifc.busWriteEnable}, 32'h0);
        chk("rst_irq",   {31'b0, ifc.irq}, 32'h0);
        chk("rst_addr",  ifc.busAddress, 32'h0);
        chk("rst_instr", {31'b0, ifc.busInstr}, 32'h0);
        rd(2'd3, s); chk("rst_status", s, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // register readback
        wr(2'd0, 32'h1234_5677); rd(2'd0, s); chk("src_readback", s, 32'h1234_5674);
        wr(2'd1, 32'h0006_0003); rd(2'd1, s); chk("dst_readback", s, 32'h0006_0000);
        wr(2'd2, 32'hABCD_0005); rd(2'd2, s); chk("len_readback", s, 32'h0000_0005);

        // table-driven copy vectors
        for (int v = 0; v < 5; v++) begin
            r0 = rd_beats; w0 = wr_beats; g0 = gap_viol; st0 = stab_viol;
            gv0 = gnt_viol; q0 = req_cycles;
            rdy_dly      = vecs[v].dly;
            ifc.busGrant = (vecs[v].gnt_hold == 0);
            wr(2'd0, vecs[v].src);
            wr(2'd1, vecs[v].dst);
            wr(2'd2, {16'h0, vecs[v].len});
            wr(2'd3, 32'h1);
            if (vecs[v].len == 0) begin
                rd(2'd3, s);
                chk($sformatf("v%0d_len0_done", v), s, 32'h0000_0002);
            end
            if (vecs[v].gnt_hold > 0) begin
                repeat (vecs[v].gnt_hold) @(negedge clk);
                chk($sformatf("v%0d_req_nogrant", v), {31'b0, ifc.busRequest}, 32'h1);
                chk($sformatf("v%0d_reads_nogrant", v), rd_beats - r0, 0);
                ifc.busGrant = 1'b1;
            end
            wait_idle();
            rd(2'd3, s);
            chk($sformatf("v%0d_status", v), s, vecs[v].exp_stat);
            chk($sformatf("v%0d_rd_beats", v), rd_beats - r0, vecs[v].exp_rd);
            chk($sformatf("v%0d_wr_beats", v), wr_beats - w0, vecs[v].exp_wr);
            chk($sformatf("v%0d_gap", v), gap_viol - g0, 0);
            chk($sformatf("v%0d_stable", v), stab_viol - st0, 0);
            chk($sformatf("v%0d_grant", v), gnt_viol - gv0, 0);
            if (vecs[v].len == 0)
                chk($sformatf("v%0d_no_request", v), req_cycles - q0, 0);
            for (int i = 0; i < int'(vecs[v].len); i++)
                chk($sformatf("v%0d_data%0d", v, i), wmem[idx(vecs[v].dst + 32'(4 * i))],
                    rom_fn(vecs[v].src + 32'(4 * i)));
        end

        // start+clear-done together: start wins; config writes while busy ignored
        wr(2'd0, 32'h0000_0200); wr(2'd1, 32'h0006_0000); wr(2'd2, 32'h2);
        wr(2'd3, 32'h9);
        rd(2'd3, s); chk("start_clr_status", s, 32'h0002_0001);
        wr(2'd1, 32'hDEAD_0000);
        wait_idle();
        rd(2'd1, s); chk("dst_busy_ignored", s, 32'h0006_0000);
        rd(2'd3, s); chk("start_clr_done", s, 32'h0000_0002);
        wr(2'd3, 32'h8);
        rd(2'd3, s); chk("clear_done", s, 32'h0);

        // abort during RD_REQ of word 2 of 5
        r0 = rd_beats; w0 = wr_beats;
        wr(2'd0, 32'h0000_0300); wr(2'd1, 32'h0007_0000); wr(2'd2, 32'h5);
        wr(2'd3, 32'h11);
        n = 0;
        while (!((wr_beats - w0) == 1 && ifc.busValid && !ifc.busWriteEnable) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_word2", {31'b0, n < 500}, 32'h1);
        wr(2'd3, 32'h14);
        wait_idle();
        rd(2'd3, s); chk("abort_status", s, 32'h0003_0014);
        chk("abort_irq", {31'b0, ifc.irq}, 32'h1);
        chk("abort_rd_beats", rd_beats - r0, 2);
        chk("abort_wr_beats", wr_beats - w0, 2);
        chk("abort_word2_data", wmem[idx(32'h0007_0004)], rom_fn(32'h0000_0304));
        chk("abort_word3_untouched", {31'b0, wvld[idx(32'h0007_0008)]}, 32'h0);

        // asynchronous reset in the middle of a write beat
        rdy_dly = 3;
        wr(2'd0, 32'h0000_0400); wr(2'd1, 32'h0008_0000); wr(2'd2, 32'h4);
        wr(2'd3, 32'h11);
        n = 0;
        while (!(ifc.busValid && ifc.busWriteEnable) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wr", {31'b0, n < 500}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, ifc.busValid}, 32'h0);
        chk("midrst_req",   {31'b0, ifc.busRequest}, 32'h0);
        chk("midrst_irq",   {31'b0, ifc.irq}, 32'h0);
        rd(2'd3, s); chk("midrst_status", s, 32'h0);
        rd(2'd0, s); chk("midrst_src", s, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        rdy_dly = 0;
        @(negedge clk);

`ifdef DMA_FILL_EN
        r0 = rd_beats; w0 = wr_beats;
        wr(2'd0, 32'hDEAD_BEEF); wr(2'd1, 32'h0009_0000); wr(2'd2, 32'h3);
        wr(2'd3, 32'h3);
        rd(2'd3, s); chk("fill_status_busy", s, 32'h0003_0009);
        wait_idle();
        rd(2'd3, s); chk("fill_status_done", s, 32'h0000_000A);
        chk("fill_rd_beats", rd_beats - r0, 0);
        chk("fill_wr_beats", wr_beats - w0, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fill_data%0d", i), wmem[idx(32'h0009_0000 + 32'(4 * i))], 32'hDEAD_BEEF);
        rd(2'd0, s); chk("fill_src_readback", s, 32'hDEAD_BEEC);
`else
        r0 = rd_beats; w0 = wr_beats;
        wr(2'd0, 32'h0000_0500); wr(2'd1, 32'h000A_0000); wr(2'd2, 32'h1);
        wr(2'd3, 32'h3);
        rd(2'd3, s); chk("nofill_status_busy", s, 32'h0001_0001);
        wait_idle();
        chk("nofill_rd_beats", rd_beats - r0, 1);
        chk("nofill_wr_beats", wr_beats - w0, 1);
        chk("nofill_data", wmem[idx(32'h000A_0000)], rom_fn(32'h0000_0500));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
